// File: rtl/shift_deser8.sv
// Serial-to-parallel receiver: assembles MSB- or LSB-first bits into a word and
// hands each completed word to a single-entry valid/ready output buffer.
module shift_deser8 #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             serial_in,
   input  logic [1:0]       shift_direction,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             overrun,
   output logic [CNT_W-1:0] bit_count
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ovr_q, ovr_d;
   logic             accept_s, resync_s, complete_s;

   // Decode the bit strobe into accept / resync / word-complete events.
   always_comb begin
      accept_s   = enable && ((shift_direction == 2'b00) || (shift_direction == 2'b10));
      resync_s   = enable && (shift_direction == 2'b11);
      complete_s = accept_s && (cnt_q == LAST_CNT);
   end

   // Shift register and bit counter next state.
   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (resync_s) begin
         sreg_d = {WIDTH{1'b0}};
         cnt_d  = {CNT_W{1'b0}};
      end else if (accept_s) begin
         if (shift_direction[1] == 1'b0) begin
            sreg_d = {sreg_q[WIDTH-2:0], serial_in};
         end else begin
            sreg_d = {serial_in, sreg_q[WIDTH-1:1]};
         end
         if (cnt_q == LAST_CNT) begin
            cnt_d = {CNT_W{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         sreg_d = sreg_q;
         cnt_d  = cnt_q;
      end
   end

   // Shift register and bit counter state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg_q <= {WIDTH{1'b0}};
         cnt_q  <= {CNT_W{1'b0}};
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

   // Output buffer FSM: state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         data_q  <= {WIDTH{1'b0}};
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         ovr_q   <= ovr_d;
      end
   end

   // Output buffer FSM: next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (complete_s) begin
               state_d = ST_FULL;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (data_ready && !complete_s) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_FULL;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Output buffer FSM: buffer load and overrun pulse; a full buffer that is
   // not being drained drops the new word rather than overwriting.
   always_comb begin
      data_d = data_q;
      ovr_d  = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (complete_s) begin
               data_d = sreg_d;
            end else begin
               data_d = data_q;
            end
         end
         ST_FULL: begin
            if (complete_s && data_ready) begin
               data_d = sreg_d;
            end else if (complete_s) begin
               ovr_d = 1'b1;
            end else begin
               data_d = data_q;
            end
         end
         default: begin
            data_d = data_q;
            ovr_d  = 1'b0;
         end
      endcase
   end

   assign data_out   = data_q;
   assign data_valid = (state_q == ST_FULL);
   assign overrun    = ovr_q;
   assign bit_count  = cnt_q;

endmodule
